// File: rtl/spart_rx_fifo.sv
// spart_rx_fifo: oversampling serial receiver (5..8 data bits, optional parity) feeding a
// first-word-fall-through FIFO, with sticky error flags and break detection.
module spart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rxd,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic                        rx_rd,
    input  logic                        err_clr,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun,
    output logic                        break_det
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [OW-1:0] S_LO  = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [OW-1:0] S_MID = OW'(OVERSAMPLE / 2);
    localparam logic [OW-1:0] S_HI  = OW'(OVERSAMPLE / 2 + 1);
    localparam logic [OW-1:0] S_END = OW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t               state;
    logic                 rx_m, rxs;
    logic [DIV_W-1:0]     div_cnt, div_q;
    logic [OW-1:0]        os_cnt;
    logic [1:0]           smp;
    logic                 m;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 wr_req;
    logic                 tick, mid, bit_end, maj, start_go;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr, rd_nx;
    logic [CW-1:0]        cnt_nx;
    logic                 full, pop, wr_en;

    always_comb begin
        tick     = div_cnt == div_q;
        mid      = tick && os_cnt == S_HI;
        bit_end  = tick && os_cnt == S_END;
        maj      = (smp[0] & smp[1]) | ((smp[0] | smp[1]) & rxs);
        start_go = state == IDLE && !rxs;
        full     = fifo_count == CW'(FIFO_DEPTH);
        pop      = rx_rd && rx_valid;
        wr_en    = wr_req && (!full || pop);
        rd_nx    = pop ? rd_ptr + AW'(1) : rd_ptr;
        cnt_nx   = fifo_count + CW'(wr_en) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) {rx_m, rxs} <= 2'b11;
        else {rx_m, rxs} <= {rxd, rx_m};

    // Free-running tick divider, realigned to the start edge so bit slots line up with the line
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            div_cnt <= '0;
            div_q   <= '0;
            os_cnt  <= '0;
        end else if (start_go) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            div_q   <= baud_div;
            os_cnt  <= os_cnt == S_END ? '0 : os_cnt + OW'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            smp        <= 2'b11;
            m          <= 1'b1;
            wr_req     <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            wr_req    <= 1'b0;
            break_det <= 1'b0;
            if (err_clr) begin
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
            end
            if (tick && os_cnt == S_LO) smp[0] <= rxs;
            if (tick && os_cnt == S_MID) smp[1] <= rxs;
            if (mid) m <= maj;
            case (state)
                IDLE: if (!rxs) state <= START;
                START: if (bit_end) begin
                    state   <= m ? IDLE : DATA;
                    bit_idx <= '0;
                end
                DATA: if (bit_end) begin
                    shreg   <= {m, shreg[DATA_BITS-1:1]};
                    bit_idx <= bit_idx + BW'(1);
                    if (bit_idx == B_END) state <= PARITY != 0 ? PAR : STOP;
                end
                PAR: if (bit_end) begin
                    if ((^shreg ^ m) != (PARITY == 2)) parity_err <= 1'b1;
                    state <= STOP;
                end
                // Decided at mid-bit so a start edge right after the stop bit is not missed
                STOP: if (mid) begin
                    if (!maj && shreg == '0) begin
                        break_det <= 1'b1;
                        state     <= BRK;
                    end else begin
                        wr_req <= 1'b1;
                        if (!maj) frame_err <= 1'b1;
                        state <= IDLE;
                    end
                end
                BRK: if (rxs) state <= IDLE;
                default: state <= IDLE;
            endcase
        end

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= shreg;

    // Head register looks ahead so the output reflects the state after this cycle's push/pop
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            overrun    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr     <= rd_nx;
            fifo_count <= cnt_nx;
            rx_valid   <= cnt_nx != '0;
            rx_data    <= (wr_en && rd_nx == wr_ptr) ? shreg : mem[rd_nx];
            if (err_clr) overrun <= 1'b0;
            if (wr_req && full && !pop) overrun <= 1'b1;
        end
endmodule
